// File: rtl/disp_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : disp_out_pkg
//  Purpose : Shared types and constants for the disparity colour-output stage.
//            - Colormap segment codes (top two bits of the 8-bit disparity).
//            - Fixed pixel-pipeline latency.
//            - RGB888 pixel type and the delay-matched sync bundle.
//  Rev     : 1.0  initial release
// ============================================================================
package disp_out_pkg;

    // Colormap segment selected by d[7:6], in ascending disparity order.
    localparam logic [1:0] SEG_BLUE   = 2'd0;  // blue   -> cyan
    localparam logic [1:0] SEG_CYAN   = 2'd1;  // cyan   -> green
    localparam logic [1:0] SEG_YELLOW = 2'd2;  // green  -> yellow
    localparam logic [1:0] SEG_RED    = 2'd3;  // yellow -> red

    // Cycles from input sample to rgb_out / out_* syncs.
    localparam int DISP_PIPE_LAT = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/disp_colormap_out_if.sv
`default_nettype none
// ============================================================================
//  Module  : disp_colormap_out_if
//  Purpose : Disparity pixel stream (syncs, qualifier, pixel) feeding the
//            colour-output stage.
//  Ports   : hsync, vsync, valid (1 bit each), data_in (WIDTH bits)
//            master = stream source, slave = stream sink
//  Rev     : 1.0  initial release
// ============================================================================
interface disp_colormap_out_if #(
    parameter int WIDTH = 8
);
    logic             hsync;
    logic             vsync;
    logic             valid;
    logic [WIDTH-1:0] data_in;

    modport master (output hsync, vsync, valid, data_in);
    modport slave  (input  hsync, vsync, valid, data_in);
endinterface
`default_nettype wire

// File: rtl/disp_cmap_lut.sv
`default_nettype none
// ============================================================================
//  Module  : disp_cmap_lut
//  Purpose : Purely combinational jet-style colormap, 8-bit disparity to
//            RGB888. Zero disparity is rendered black. With i_gray set the
//            disparity is replicated on all three channels instead.
//  Ports   : i_d    [7:0]  disparity (top 8 bits of the pixel)
//            i_gray        grey-ramp select
//            o_rgb  rgb_t  colour result
//  Rev     : 1.0  initial release
// ============================================================================
module disp_cmap_lut
    import disp_out_pkg::*;
(
    input  wire logic [7:0] i_d,
    input  wire logic       i_gray,
    output rgb_t            o_rgb
);

    logic [1:0] w_seg;
    logic [7:0] w_off;

    assign w_seg = i_d[7:6];
    // Position within the segment scaled to 0..252; 255-w_off never wraps.
    assign w_off = {i_d[5:0], 2'b00};

    always_comb begin
        o_rgb = '0;
        if (i_d == 8'd0) begin
            o_rgb = '0;
        end else if (i_gray) begin
            o_rgb.r = i_d;
            o_rgb.g = i_d;
            o_rgb.b = i_d;
        end else begin
            case (w_seg)
                SEG_BLUE: begin
                    o_rgb.r = 8'h00;
                    o_rgb.g = w_off;
                    o_rgb.b = 8'hFF;
                end
                SEG_CYAN: begin
                    o_rgb.r = 8'h00;
                    o_rgb.g = 8'hFF;
                    o_rgb.b = 8'hFF - w_off;
                end
                SEG_YELLOW: begin
                    o_rgb.r = w_off;
                    o_rgb.g = 8'hFF;
                    o_rgb.b = 8'h00;
                end
                SEG_RED: begin
                    o_rgb.r = 8'hFF;
                    o_rgb.g = 8'hFF - w_off;
                    o_rgb.b = 8'h00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_colormap_out.sv
`default_nettype none
// ============================================================================
//  Module  : disp_colormap_out
//  Purpose : Display-side colour stage in the rd_clk domain. Maps each
//            disparity pixel to RGB888 through a jet colormap with syncs and
//            DE delay-matched (2 cycles), and measures the active geometry of
//            every frame against the programmed size.
//  Ports   : rd_clk, rd_rst        clock, synchronous active-high reset
//            pix_in (slave)        hsync/vsync/valid/data_in stream
//            gray_mode             grey-ramp select (DISP_GRAY_BYPASS_EN only)
//            exp_width/exp_height  expected active size (quasi-static)
//            rgb_out, out_hsync, out_vsync, out_de   delayed video out
//            meas_width/meas_height, geom_err, frame_done  geometry report
//  Config  : `define DISP_GRAY_BYPASS_EN adds the gray_mode input.
//            WIDTH must be >= 8; only the top 8 pixel bits reach the LUT.
//  Rev     : 1.0  initial release
// ============================================================================
module disp_colormap_out
    import disp_out_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 11
) (
    input  wire logic             rd_clk,
    input  wire logic             rd_rst,
    disp_colormap_out_if.slave    pix_in,
`ifdef DISP_GRAY_BYPASS_EN
    input  wire logic             gray_mode,
`endif
    input  wire logic [CNT_W-1:0] exp_width,
    input  wire logic [CNT_W-1:0] exp_height,
    output logic      [23:0]      rgb_out,
    output logic                  out_hsync,
    output logic                  out_vsync,
    output logic                  out_de,
    output logic      [CNT_W-1:0] meas_width,
    output logic      [CNT_W-1:0] meas_height,
    output logic                  geom_err,
    output logic                  frame_done
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Pixel pipeline: S1 = r_s1_d / r_sync[0], S2 = r_rgb / r_sync[1]
    // ------------------------------------------------------------------
    logic        w_gray_in;
    logic [7:0]  r_s1_d;
    logic        r_s1_gray;
    sync_t       r_sync [DISP_PIPE_LAT];
    rgb_t        w_rgb;
    rgb_t        r_rgb;

`ifdef DISP_GRAY_BYPASS_EN
    assign w_gray_in = gray_mode;
`else
    assign w_gray_in = 1'b0;
`endif

    disp_cmap_lut u_lut (
        .i_d    (r_s1_d),
        .i_gray (r_s1_gray),
        .o_rgb  (w_rgb)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_s1_d    <= '0;
            r_s1_gray <= 1'b0;
            r_rgb     <= '0;
            for (int i = 0; i < DISP_PIPE_LAT; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_s1_d    <= pix_in.data_in[WIDTH-1 -: 8];
            r_s1_gray <= w_gray_in;
            r_sync[0] <= '{hs: pix_in.hsync, vs: pix_in.vsync, de: pix_in.valid};
            for (int i = 1; i < DISP_PIPE_LAT; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            // Blanking pixels are forced black regardless of their data.
            r_rgb     <= r_sync[0].de ? w_rgb : '0;
        end
    end

    assign rgb_out   = r_rgb;
    assign out_hsync = r_sync[DISP_PIPE_LAT-1].hs;
    assign out_vsync = r_sync[DISP_PIPE_LAT-1].vs;
    assign out_de    = r_sync[DISP_PIPE_LAT-1].de;

    // ------------------------------------------------------------------
    // Geometry measurement. Edges are taken between the S1 copy of
    // valid/vsync and one further registered copy.
    // ------------------------------------------------------------------
    logic             w_s1_valid;
    logic             w_s1_vs;
    logic             r_prev_valid;
    logic             r_prev_vs;
    logic             w_line_end;
    logic             w_frame_start;

    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_first_w;
    logic             r_line_err;
    logic             r_seen_vs;

    logic [CNT_W-1:0] w_line_cnt_nx;
    logic [CNT_W-1:0] w_first_w_nx;
    logic             w_line_err_nx;

    logic [CNT_W-1:0] r_meas_width;
    logic [CNT_W-1:0] r_meas_height;
    logic             r_geom_err;
    logic             r_frame_done;

    assign w_s1_valid    = r_sync[0].de;
    assign w_s1_vs       = r_sync[0].vs;
    assign w_line_end    = r_prev_valid & ~w_s1_valid;
    assign w_frame_start = w_s1_vs & ~r_prev_vs;

    // Line bookkeeping after accounting for a line ending this cycle. The
    // frame latch reads these so a line ending together with vsync counts.
    always_comb begin
        w_line_cnt_nx = r_line_cnt;
        w_first_w_nx  = r_first_w;
        w_line_err_nx = r_line_err;
        if (w_line_end) begin
            if (r_line_cnt == '0) begin
                w_first_w_nx = r_pix_cnt;
            end else if (r_pix_cnt != r_first_w) begin
                w_line_err_nx = 1'b1;
            end
            if (r_line_cnt != c_cnt_max) begin
                w_line_cnt_nx = r_line_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_prev_valid  <= 1'b0;
            r_prev_vs     <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_first_w     <= '0;
            r_line_err    <= 1'b0;
            r_seen_vs     <= 1'b0;
            r_meas_width  <= '0;
            r_meas_height <= '0;
            r_geom_err    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_prev_valid <= w_s1_valid;
            r_prev_vs    <= w_s1_vs;
            r_frame_done <= 1'b0;

            // pix_cnt still holds the finished line's width during the
            // line-end cycle, so it is consumed above before clearing here.
            if (w_line_end) begin
                r_pix_cnt <= '0;
            end else if (w_s1_valid && (r_pix_cnt != c_cnt_max)) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if (w_frame_start) begin
                // The first vsync after reset only arms measurement; the
                // partial frame before it is discarded.
                if (r_seen_vs) begin
                    r_meas_width  <= w_first_w_nx;
                    r_meas_height <= w_line_cnt_nx;
                    r_geom_err    <= w_line_err_nx
                                   | (w_first_w_nx  != exp_width)
                                   | (w_line_cnt_nx != exp_height);
                    r_frame_done  <= 1'b1;
                end
                r_seen_vs  <= 1'b1;
                r_line_cnt <= '0;
                r_first_w  <= '0;
                r_line_err <= 1'b0;
            end else begin
                r_line_cnt <= w_line_cnt_nx;
                r_first_w  <= w_first_w_nx;
                r_line_err <= w_line_err_nx;
            end
        end
    end

    assign meas_width  = r_meas_width;
    assign meas_height = r_meas_height;
    assign geom_err    = r_geom_err;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_disp_colormap_out.sv
`default_nettype none
// ============================================================================
//  Module  : tb_disp_colormap_out
//  Purpose : Self-checking bench for disp_colormap_out. Pixel outputs are
//            checked against a scoreboard of expected values queued when the
//            stimulus is driven; geometry outputs against constants derived
//            from the generated frame shapes.
//  Config  : DISP_GRAY_BYPASS_EN enables the grey-ramp scenario.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_disp_colormap_out;
    import disp_out_pkg::*;

    localparam int c_w = 640;
    localparam int c_h = 6;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic [10:0] exp_width  = 11'd640;
    logic [10:0] exp_height = 11'd6;
    logic [23:0] rgb_out;
    logic        out_hsync, out_vsync, out_de;
    logic [10:0] meas_width, meas_height;
    logic        geom_err, frame_done;
`ifdef DISP_GRAY_BYPASS_EN
    logic        gray_mode = 1'b0;
`endif

    disp_colormap_out_if #(.WIDTH(8)) pix_if ();

    disp_colormap_out #(.WIDTH(8), .CNT_W(11)) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .pix_in      (pix_if),
`ifdef DISP_GRAY_BYPASS_EN
        .gray_mode   (gray_mode),
`endif
        .exp_width   (exp_width),
        .exp_height  (exp_height),
        .rgb_out     (rgb_out),
        .out_hsync   (out_hsync),
        .out_vsync   (out_vsync),
        .out_de      (out_de),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .geom_err    (geom_err),
        .frame_done  (frame_done)
    );

    always #5 rd_clk = ~rd_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;

    typedef struct {
        int          due;
        logic [7:0]  d;
        logic [26:0] exp;   // {rgb, hs, vs, de}
    } sb_t;
    sb_t sb_q[$];

    always @(negedge rd_clk) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent colormap model: segment = d/64, offset = (d mod 64)*4.
    function automatic logic [23:0] cmap_ref(input int d, input bit gray);
        int seg, off, r, g, b;
        if (d == 0) return 24'h0;
        if (gray) return {d[7:0], d[7:0], d[7:0]};
        seg = d / 64;
        off = (d % 64) * 4;
        case (seg)
            0:       begin r = 0;   g = off;       b = 255;       end
            1:       begin r = 0;   g = 255;       b = 255 - off; end
            2:       begin r = off; g = 255;       b = 0;         end
            default: begin r = 255; g = 255 - off; b = 0;         end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic v, input logic [7:0] d);
        @(negedge rd_clk);
        pix_if.hsync   = hs;
        pix_if.vsync   = vs;
        pix_if.valid   = v;
        pix_if.data_in = d;
    endtask

    // n valid pixels; then either hsync blanking or a vsync whose rising
    // edge lands exactly on the valid falling edge.
    task automatic send_line(input int n, input bit vs_end);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, i[7:0] | 8'h01);
        if (vs_end) begin
            repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
            repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
        end else begin
            repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
            repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic send_vsync();
        repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int lines, input int short_idx);
        for (int l = 0; l < lines; l++) send_line((l == short_idx) ? c_w - 1 : c_w, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        repeat (3) @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        pix_if.hsync = 1'b1; pix_if.vsync = 1'b1; pix_if.valid = 1'b1; pix_if.data_in = 8'hFF;
        rd_rst = 1'b1;
        repeat (3) @(negedge rd_clk);
        n_tests++;
        if ({rgb_out, out_hsync, out_vsync, out_de} !== 27'h0) begin
            n_fail++; $display("FAIL reset_video got=%h expected=0", {rgb_out, out_hsync, out_vsync, out_de});
        end
        n_tests++;
        if ({meas_width, meas_height, geom_err, frame_done} !== 24'h0) begin
            n_fail++; $display("FAIL reset_geom got w=%0d h=%0d err=%b done=%b expected all 0", meas_width, meas_height, geom_err, frame_done);
        end
        rd_rst = 1'b0;
        pix_if.hsync = 1'b0; pix_if.vsync = 1'b0; pix_if.valid = 1'b0; pix_if.data_in = 8'h00;
        base = fd_cnt;
        send_vsync();
        n_tests++;
        if (fd_cnt !== base) begin
            n_fail++; $display("FAIL reset_first_vsync frame_done count=%0d expected %0d", fd_cnt, base);
        end
    endtask

    task automatic run_pixels(input logic [7:0] tbl [], input logic vtbl [], input bit gray, input string tag);
        sb_t e;
        int  n = tbl.size();
        for (int i = 0; i < n + DISP_PIPE_LAT + 1; i++) begin
            @(negedge rd_clk);
            if (sb_q.size() > 0 && sb_q[0].due == i) begin
                e = sb_q.pop_front();
                n_tests++;
                if ({rgb_out, out_hsync, out_vsync, out_de} !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s[d=%02h] got rgb/hs/vs/de=%h_%b%b%b expected %h_%b%b%b", tag, e.d,
                             rgb_out, out_hsync, out_vsync, out_de, e.exp[26:3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
            if (i < n) begin
                pix_if.data_in = tbl[i];
                pix_if.valid   = vtbl[i];
                pix_if.hsync   = i[0];
                pix_if.vsync   = (i % 5 == 0);
                e.due = i + DISP_PIPE_LAT;
                e.d   = tbl[i];
                e.exp = {vtbl[i] ? cmap_ref(int'(tbl[i]), gray) : 24'h0, i[0], (i % 5 == 0), vtbl[i]};
                sb_q.push_back(e);
            end else begin
                pix_if.valid = 1'b0; pix_if.hsync = 1'b0; pix_if.vsync = 1'b0; pix_if.data_in = 8'h00;
            end
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL %s_drain pending=%0d expected 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_colormap();
        logic [7:0] d_tbl [] = '{8'd0, 8'd1, 8'd63, 8'd64, 8'd128, 8'd192, 8'd200, 8'd255,
                                 8'd128, 8'd37, 8'd150, 8'd233, 8'd0, 8'd0};
        logic       v_tbl [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        d_tbl[12] = 8'($urandom_range(1, 255));
        d_tbl[13] = 8'($urandom_range(1, 255));
        run_pixels(d_tbl, v_tbl, 1'b0, "cmap");
    endtask

    task automatic test_gray();
`ifdef DISP_GRAY_BYPASS_EN
        logic [7:0] d_tbl [] = '{8'h80, 8'h00, 8'h33, 8'hFF};
        logic       v_tbl [] = '{1'b1, 1'b1, 1'b1, 1'b1};
        gray_mode = 1'b1;
        run_pixels(d_tbl, v_tbl, 1'b1, "gray");
        gray_mode = 1'b0;
`endif
    endtask

    task automatic test_clean_frames();
        int base;
        pulse_reset();
        base = fd_cnt;
        send_vsync();
        n_tests++;
        if (fd_cnt !== base) begin n_fail++; $display("FAIL clean_arm frame_done count=%0d expected %0d", fd_cnt, base); end
        for (int f = 1; f <= 2; f++) begin
            send_frame(c_h, -1);
            send_vsync();
            n_tests++;
            if (fd_cnt !== base + f) begin n_fail++; $display("FAIL clean_done%0d count=%0d expected %0d", f, fd_cnt, base + f); end
            n_tests++;
            if (meas_width !== 11'd640) begin n_fail++; $display("FAIL clean_width%0d got=%0d expected 640", f, meas_width); end
            n_tests++;
            if (meas_height !== 11'd6) begin n_fail++; $display("FAIL clean_height%0d got=%0d expected 6", f, meas_height); end
            n_tests++;
            if (geom_err !== 1'b0) begin n_fail++; $display("FAIL clean_err%0d got=%b expected 0", f, geom_err); end
        end
    endtask

    task automatic test_short_line();
        int base = fd_cnt;
        send_frame(c_h, 1);
        send_vsync();
        n_tests++;
        if (fd_cnt !== base + 1) begin n_fail++; $display("FAIL short_done count=%0d expected %0d", fd_cnt, base + 1); end
        n_tests++;
        if ({meas_width, meas_height, geom_err} !== {11'd640, 11'd6, 1'b1}) begin
            n_fail++; $display("FAIL short_err got w=%0d h=%0d err=%b expected 640/6/1", meas_width, meas_height, geom_err);
        end
        send_frame(c_h, -1);
        send_vsync();
        n_tests++;
        if (geom_err !== 1'b0) begin n_fail++; $display("FAIL short_recover got err=%b expected 0", geom_err); end
    endtask

    task automatic test_coincident();
        int base = fd_cnt;
        send_frame(c_h - 1, -1);
        send_line(c_w, 1'b1);
        n_tests++;
        if (fd_cnt !== base + 1) begin n_fail++; $display("FAIL coinc_done count=%0d expected %0d", fd_cnt, base + 1); end
        n_tests++;
        if ({meas_width, meas_height, geom_err} !== {11'd640, 11'd6, 1'b0}) begin
            n_fail++; $display("FAIL coinc_meas got w=%0d h=%0d err=%b expected 640/6/0", meas_width, meas_height, geom_err);
        end
    endtask

    task automatic test_boundaries();
        int base = fd_cnt;
        send_vsync();
        n_tests++;
        if ({meas_width, meas_height, geom_err} !== {11'd0, 11'd0, 1'b1}) begin
            n_fail++; $display("FAIL zero_lines got w=%0d h=%0d err=%b expected 0/0/1", meas_width, meas_height, geom_err);
        end
        send_line(2100, 1'b0);
        send_vsync();
        n_tests++;
        if (fd_cnt !== base + 2) begin n_fail++; $display("FAIL sat_done count=%0d expected %0d", fd_cnt, base + 2); end
        n_tests++;
        if ({meas_width, meas_height, geom_err} !== {11'd2047, 11'd1, 1'b1}) begin
            n_fail++; $display("FAIL sat_width got w=%0d h=%0d err=%b expected 2047/1/1", meas_width, meas_height, geom_err);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        repeat (4) drive(1'b1, 1'b0, 1'b1, 8'h80);
        rd_rst = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b1, 8'h80);
        n_tests++;
        if ({rgb_out, out_hsync, out_vsync, out_de} !== 27'h0) begin
            n_fail++; $display("FAIL midrst_video got=%h expected=0", {rgb_out, out_hsync, out_vsync, out_de});
        end
        n_tests++;
        if ({meas_width, meas_height, geom_err, frame_done} !== 24'h0) begin
            n_fail++; $display("FAIL midrst_geom got w=%0d h=%0d err=%b done=%b expected all 0", meas_width, meas_height, geom_err, frame_done);
        end
        rd_rst = 1'b0;
        pix_if.hsync = 1'b0; pix_if.vsync = 1'b0; pix_if.valid = 1'b0; pix_if.data_in = 8'h00;
        base = fd_cnt;
        send_vsync();
        n_tests++;
        if (fd_cnt !== base) begin n_fail++; $display("FAIL midrst_arm frame_done count=%0d expected %0d", fd_cnt, base); end
        send_frame(c_h, -1);
        send_vsync();
        n_tests++;
        if ({meas_width, meas_height, geom_err} !== {11'd640, 11'd6, 1'b0} || fd_cnt !== base + 1) begin
            n_fail++; $display("FAIL midrst_frame got w=%0d h=%0d err=%b done=%0d expected 640/6/0 done=%0d",
                               meas_width, meas_height, geom_err, fd_cnt, base + 1);
        end
    endtask

    initial begin
        test_reset();
        test_colormap();
        test_clean_frames();
        test_short_line();
        test_coincident();
        test_boundaries();
        test_mid_reset();
        test_gray();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
